// File: rtl/matris_gonderici_pkg.sv
// rtl/matris_gonderici_pkg.sv - shared constants and FSM encoding for the matrix sender
package matris_gonderici_pkg;

    localparam int M_VARSAYILAN           = 16;
    localparam int ZAMAN_ASIMI_VARSAYILAN = 64;
    localparam int KELIME_SAYISI          = 16;
    localparam int SONUC_SAYISI           = 4;

    typedef enum logic [2:0] {
        BOS    = 3'd0,
        GONDER = 3'd1,
        BEKLE  = 3'd2,
        BITTI  = 3'd3,
        HATA   = 3'd4
    } durum_t;

endpackage

// File: rtl/matris_gonderici_bellek.sv
// rtl/matris_gonderici_bellek.sv - 16xM operand store, one write port, one combinational read port
module matris_bellek
    import matris_gonderici_pkg::*;
#(
    parameter int M = M_VARSAYILAN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         yaz_gecerli,
    input  logic [3:0]   yaz_adres,
    input  logic [M-1:0] yaz_veri,
    input  logic [3:0]   oku_adres,
    output logic [M-1:0] oku_veri
);

    logic [M-1:0] bellek [KELIME_SAYISI];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < KELIME_SAYISI; i++) begin
                bellek[i] <= '0;
            end
        end else if (yaz_gecerli) begin
            bellek[yaz_adres] <= yaz_veri;
        end
    end

    assign oku_veri = bellek[oku_adres];

endmodule

// File: rtl/matris_gonderici.sv
// rtl/matris_gonderici.sv - streams a 2x4 and a 4x2 operand matrix out and captures the four product words
module matris_gonderici
    import matris_gonderici_pkg::*;
#(
    parameter int M           = M_VARSAYILAN,
    parameter int ZAMAN_ASIMI = ZAMAN_ASIMI_VARSAYILAN
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           yaz_gecerli,
    input  logic [3:0]     yaz_adres,
    input  logic [M-1:0]   yaz_veri,
    input  logic           baslat,
    output logic [M-1:0]   matris_veri,
    output logic           matris_gecerli,
    input  logic [2*M+1:0] carpim_veri,
    input  logic           carpim_gecerli,
    input  logic [1:0]     oku_adres,
    output logic [2*M+1:0] sonuc_veri,
    output logic           mesgul,
    output logic           bitti,
    output logic           hata
);

    localparam int ZW = $clog2(ZAMAN_ASIMI + 1);

    durum_t         durum, durum_sonraki;
    logic [3:0]     gonder_sayac;
    logic [1:0]     sonuc_sayac;
    logic [ZW-1:0]  zaman_sayac;
    logic [2*M+1:0] sonuc [SONUC_SAYISI];
    logic [M-1:0]   bellek_veri;
    logic           baslat_kabul;
    logic           yakala;

    assign mesgul       = (durum == GONDER) || (durum == BEKLE);
    assign bitti        = (durum == BITTI);
    assign hata         = (durum == HATA);
    assign baslat_kabul = baslat && !mesgul;
    assign yakala       = (durum == BEKLE) && carpim_gecerli;

    matris_bellek #(.M(M)) u_bellek (
        .clk         (clk),
        .rst         (rst),
        .yaz_gecerli (yaz_gecerli && !mesgul),
        .yaz_adres   (yaz_adres),
        .yaz_veri    (yaz_veri),
        .oku_adres   (gonder_sayac),
        .oku_veri    (bellek_veri)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum <= BOS;
        end else begin
            durum <= durum_sonraki;
        end
    end

    always_comb begin
        durum_sonraki = durum;
        case (durum)
            BOS, BITTI, HATA: begin
                if (baslat) durum_sonraki = GONDER;
            end
            GONDER: begin
                if (gonder_sayac == 4'(KELIME_SAYISI - 1)) durum_sonraki = BEKLE;
            end
            BEKLE: begin
                // A capture on the expiry cycle wins over the timeout.
                if (yakala && (sonuc_sayac == 2'(SONUC_SAYISI - 1))) begin
                    durum_sonraki = BITTI;
                end else if (!yakala && (zaman_sayac == ZW'(ZAMAN_ASIMI - 1))) begin
                    durum_sonraki = HATA;
                end
            end
            default: durum_sonraki = BOS;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gonder_sayac <= '0;
            sonuc_sayac  <= '0;
            zaman_sayac  <= '0;
            for (int i = 0; i < SONUC_SAYISI; i++) begin
                sonuc[i] <= '0;
            end
        end else begin
            if (baslat_kabul) begin
                gonder_sayac <= '0;
                sonuc_sayac  <= '0;
                for (int i = 0; i < SONUC_SAYISI; i++) begin
                    sonuc[i] <= '0;
                end
            end else if (durum == GONDER) begin
                gonder_sayac <= gonder_sayac + 4'd1;
            end

            if (yakala) begin
                sonuc[sonuc_sayac] <= carpim_veri;
                sonuc_sayac        <= sonuc_sayac + 2'd1;
            end

            // Held at zero outside BEKLE, so it is already clear on entry.
            if ((durum != BEKLE) || yakala) begin
                zaman_sayac <= '0;
            end else begin
                zaman_sayac <= zaman_sayac + ZW'(1);
            end
        end
    end

    assign matris_gecerli = (durum == GONDER);
    assign matris_veri    = matris_gecerli ? bellek_veri : '0;
    assign sonuc_veri     = sonuc[oku_adres];

endmodule
